// File: rtl/program_loader.sv
// program_loader: boots the core by streaming a length-prefixed, XOR-checked
// instruction image into instruction memory while holding the core in reset.
module program_loader #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19,
  parameter int DEPTH   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               core_rst,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [ADDR_W:0]    words_loaded
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAY, CHK, DONE, ERR} state_t;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  state_t state, nxt;
  logic [7:0] len_lo, b0, b1, csum;
  logic [ADDR_W:0] len_q;
  logic [15:0] len;
  logic [1:0] idx;
  logic acc, len_bad, rsv_bad, last_word;
  assign busy      = state inside {HDR0, HDR1, PAY, CHK};
  assign in_ready  = busy;
  assign done      = state == DONE;
  assign error     = state == ERR;
  assign core_rst  = state != DONE;
  assign acc       = in_valid & in_ready;
  assign len       = {in_data, len_lo};
  assign len_bad   = len == 16'd0 || {1'b0, len} > DEPTH_L;
  assign rsv_bad   = |in_data[7:3];
  assign last_word = words_loaded == len_q - 1'b1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? HDR0 : state;
      HDR0:    nxt = acc ? HDR1 : HDR0;
      HDR1:    nxt = !acc ? HDR1 : len_bad ? ERR : PAY;
      PAY:     nxt = !(acc && idx == 2'd2) ? PAY : rsv_bad ? ERR : last_word ? CHK : PAY;
      CHK:     nxt = !acc ? CHK : in_data == csum ? DONE : ERR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      err_code     <= 2'd0;
      words_loaded <= '0;
      len_lo       <= '0;
      len_q        <= '0;
      b0           <= '0;
      b1           <= '0;
      csum         <= '0;
      idx          <= '0;
    end else begin
      state <= nxt;
      wr_en <= 1'b0;
      if (start && !busy) begin
        csum         <= '0;
        wr_addr      <= '0;
        words_loaded <= '0;
        err_code     <= 2'd0;
        idx          <= '0;
      end
      if (acc && state != CHK) csum <= csum ^ in_data;
      if (acc && state == HDR0) len_lo <= in_data;
      if (acc && state == HDR1) begin
        len_q <= len[ADDR_W:0];
        idx   <= '0;
        if (len_bad) err_code <= 2'd1;
      end
      if (acc && state == PAY) begin
        idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
        if (idx == 2'd0) b0 <= in_data;
        if (idx == 2'd1) b1 <= in_data;
        if (idx == 2'd2 && rsv_bad) err_code <= 2'd2;
        // a word with reserved bits set is never written
        if (idx == 2'd2 && !rsv_bad) begin
          wr_en        <= 1'b1;
          wr_addr      <= words_loaded[ADDR_W-1:0];
          wr_data      <= {in_data[2:0], b1, b0};
          words_loaded <= words_loaded + 1'b1;
        end
      end
      if (acc && state == CHK && in_data != csum) err_code <= 2'd3;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives byte-stream images and checks them against a stream-level reference parser.
module tb_program_loader;
  typedef logic [7:0] bq_t[$];
  logic clk, rst, start, in_valid, in_ready, wr_en, core_rst, busy, done, error;
  logic [7:0] in_data;
  logic [11:0] wr_addr;
  logic [18:0] wr_data;
  logic [1:0] err_code;
  logic [12:0] words_loaded;
  int total, bad, pos, lat, cyc;
  logic [30:0] gotw[$];

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (wr_en) gotw.push_back({wr_addr, wr_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // stream-level reference: what a correct loader must write and end up reporting
  task automatic model(input bq_t s, output logic [30:0] w[$], output int dn, output int er,
                       output int ec, output int words, output int consumed);
    int l;
    logic [7:0] x, c0, c1, c2;
    w.delete(); dn = 0; er = 0; ec = 0; words = 0;
    l = int'({s[1], s[0]});
    if (l == 0 || l > 4096) begin
      er = 1; ec = 1; consumed = 2;
      return;
    end
    x = s[0] ^ s[1];
    for (int i = 0; i < l; i++) begin
      c0 = s[2+3*i]; c1 = s[3+3*i]; c2 = s[4+3*i];
      if (c2 >= 8'd8) begin
        er = 1; ec = 2; consumed = 5 + 3*i;
        return;
      end
      x = x ^ c0 ^ c1 ^ c2;
      w.push_back({12'(i), c2[2:0], c1, c0});
      words++;
    end
    consumed = 3*l + 3;
    if (s[3*l+2] == x) dn = 1;
    else begin er = 1; ec = 3; end
  endtask

  task automatic run(input bq_t s, input int mode, input int stop_after, input int start_at);
    logic acc;
    int last;
    pos = 0; cyc = 0; last = 0;
    gotw.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!(done || error) && cyc < 2000 && !(stop_after >= 0 && pos >= stop_after)) begin
      in_valid = pos < s.size() && (mode == 0 || (mode == 1 ? cyc % 2 == 0 : $urandom_range(0, 2) != 0));
      in_data  = pos < s.size() ? s[pos] : 8'h00;
      start    = pos == start_at;
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin pos++; last = cyc; end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    lat = cyc - last;
    chk("timeout", 32'(cyc < 2000), 1);
  endtask

  task automatic check_result(input bq_t s, input string tag);
    logic [30:0] ew[$];
    int dn, er, ec, words, consumed;
    model(s, ew, dn, er, ec, words, consumed);
    chk({tag, ".nwr"}, gotw.size(), ew.size());
    for (int i = 0; i < ew.size() && i < gotw.size(); i++) chk({tag, ".wr"}, gotw[i], ew[i]);
    chk({tag, ".done"}, done, dn);
    chk({tag, ".error"}, error, er);
    chk({tag, ".err_code"}, err_code, ec);
    chk({tag, ".core_rst"}, core_rst, dn == 0);
    chk({tag, ".words"}, words_loaded, words);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".consumed"}, pos, consumed);
    chk({tag, ".latency"}, lat, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_data"}, wr_data, 0);
    chk({tag, ".core_rst"}, core_rst, 1);
    chk({tag, ".flags"}, {busy, done, error, err_code}, 0);
    chk({tag, ".words"}, words_loaded, 0);
  endtask

  initial begin
    bq_t t1, t2, s;
    int l;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12 check_reset("por");
    @(negedge clk) rst = 1'b0;

    t1 = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h05, 8'hFF, 8'h00, 8'h00, 8'hDE};
    run(t1, 0, -1, -1); check_result(t1, "good");
    chk("good.wr0", gotw.size() > 0 ? gotw[0] : 31'h0, {12'd0, 19'h51234});
    t2 = t1; t2[8] = 8'hDF;
    run(t2, 0, -1, -1); check_result(t2, "badsum");
    s = '{8'h00, 8'h00};
    run(s, 0, -1, -1); check_result(s, "len0");
    s = '{8'h01, 8'h10};
    run(s, 0, -1, -1); check_result(s, "len4097");
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'h0D};
    run(s, 0, -1, -1); check_result(s, "rsv");
    run(t1, 1, -1, -1); check_result(t1, "gaps");

    run(t1, 0, 6, -1);
    chk("mid.nwr", gotw.size(), 1);
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    @(negedge clk) rst = 1'b0;
    run(t1, 0, -1, -1); check_result(t1, "after_rst");

    run(t1, 0, -1, 4); check_result(t1, "start_mid");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart.core_rst", core_rst, 1);
    chk("restart.busy", busy, 1);
    chk("restart.words", words_loaded, 0);
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 40; k++) begin
      logic [7:0] x, c2;
      int kind;
      s.delete();
      kind = $urandom_range(0, 9);
      l = kind == 0 ? ($urandom_range(0, 1) == 1 ? 0 : 4097 + $urandom_range(0, 100)) : $urandom_range(1, 6);
      s.push_back(l[7:0]); s.push_back(l[15:8]);
      if (kind != 0) begin
        for (int i = 0; i < l; i++) begin
          c2 = 8'($urandom);
          if ($urandom_range(0, 7) != 0) c2 = c2 & 8'h07;
          s.push_back(8'($urandom)); s.push_back(8'($urandom)); s.push_back(c2);
        end
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        s.push_back(kind == 1 ? x ^ 8'($urandom_range(1, 255)) : x);
      end
      run(s, $urandom_range(0, 2), -1, $urandom_range(0, 3) == 0 ? 3 : -1);
      check_result(s, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
